// File: rtl/bram_burst_reader.sv
// bram_burst_reader
// Read-side master for the unified-buffer BRAM. Takes a (base, length) burst
// command, walks the BRAM read port one address per cycle and streams the
// words out through a small FIFO with a last-beat flag. Issue is throttled by
// FIFO occupancy so consumer backpressure never drops or repeats a word.
module bram_burst_reader #(
  parameter int RAM_WIDTH   = 128,
  parameter int RAM_DEPTH   = 256,
  parameter int FIFO_DEPTH  = 4,
  localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  bram_enb,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [RAM_WIDTH-1:0]  bram_doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [RAM_WIDTH-1:0]  m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d;

  logic [RAM_WIDTH-1:0]  data_mem [FIFO_DEPTH];
  logic                  last_mem [FIFO_DEPTH];

  logic                  issue;
  logic                  pop;
  logic                  issue_is_last;

  // Read issue and stream handshake, decoded from registered state only so
  // bram_enb/bram_addrb are settled long before the BRAM's negedge sample.
  // The BRAM registers the word on the negedge of the issue cycle, so it is
  // already valid at the posedge that closes that cycle and is pushed there.
  always_comb begin
    issue         = (state_q == S_READ) && (remaining_q != '0) &&
                    (fifo_count_q < CNT_W'(FIFO_DEPTH));
    issue_is_last = (remaining_q == (ADDR_WIDTH + 1)'(1));
    m_valid       = (fifo_count_q != '0);
    pop           = m_valid && m_ready;
    bram_enb      = issue;
    bram_addrb    = addr_q;
    cmd_ready     = (state_q == S_IDLE);
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    // NOTE: the storage array is not reset, so an empty FIFO would show stale
    // contents; gating the head with m_valid gives zero after reset instead.
    m_data        = m_valid ? data_mem[rd_ptr_q] : '0;
    m_last        = m_valid ? last_mem[rd_ptr_q] : 1'b0;
  end

  // Next-state logic for the burst FSM, address walker and FIFO pointers.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q + CNT_W'(issue) - CNT_W'(pop);

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_base_addr;
          remaining_d = cmd_len;
          state_d     = (cmd_len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        if (issue && issue_is_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && m_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      addr_d      = (addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0
                                                           : addr_q + ADDR_WIDTH'(1);
      remaining_d = remaining_q - (ADDR_WIDTH + 1)'(1);
      wr_ptr_d    = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  // Control state; an asynchronous reset drops any in-flight read and empties the FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q      <= S_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      assert (!(issue && (fifo_count_q == CNT_W'(FIFO_DEPTH))));
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // FIFO storage: capture the BRAM word and its last-beat tag on each issue.
  always_ff @(posedge clk) begin
    if (issue) begin
      data_mem[wr_ptr_q] <= bram_doutb;
      last_mem[wr_ptr_q] <= issue_is_last;
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader: BRAM model with ram[i]=i registered
// on negedge, linear sequence of bursts covering reset, wrap, backpressure,
// zero length and reset mid-burst.
module tb_bram_burst_reader;

  localparam int W  = 128;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr;
  logic [AW:0]   cmd_len;
  logic          bram_enb;
  logic [AW-1:0] bram_addrb;
  logic [W-1:0]  bram_doutb;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] ram [256];

  bram_burst_reader #(
    .RAM_WIDTH (W),
    .RAM_DEPTH (256),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_len      (cmd_len),
    .bram_enb     (bram_enb),
    .bram_addrb   (bram_addrb),
    .bram_doutb   (bram_doutb),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // BRAM read port model: registers the addressed word on the falling edge.
  always @(negedge clk) begin
    if (bram_enb) bram_doutb <= ram[bram_addrb];
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, W'(cmd_ready), W'(1));
    check({tag, "_enb"},       W'(bram_enb), W'(0));
    check({tag, "_addrb"},     W'(bram_addrb), W'(0));
    check({tag, "_m_valid"},   W'(m_valid), W'(0));
    check({tag, "_m_data"},    m_data, W'(0));
    check({tag, "_m_last"},    W'(m_last), W'(0));
    check({tag, "_busy"},      W'(busy), W'(0));
    check({tag, "_done"},      W'(done), W'(0));
  endtask

  // Present a command for one edge; returns just after the accepting edge.
  task automatic send_cmd(input logic [AW-1:0] base, input logic [AW:0] len);
    check("cmd_ready_before_cmd", W'(cmd_ready), W'(1));
    cmd_valid     = 1'b1;
    cmd_base_addr = base;
    cmd_len       = len;
    tick();
    cmd_valid     = 1'b0;
    cmd_len       = '0;
  endtask

  initial begin
    logic [AW-1:0] wrap_addr [4];
    int            issues;
    int            got;
    logic          seen_done;

    for (int i = 0; i < 256; i++) ram[i] = W'(i);
    bram_doutb    = '0;
    reset_n       = 1'b0;
    cmd_valid     = 1'b0;
    cmd_base_addr = '0;
    cmd_len       = '0;
    m_ready       = 1'b0;

    // Power-on reset values.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset_n = 1'b1;
    tick();

    // Burst 0x10 len 4, consumer always ready.
    m_ready = 1'b1;
    send_cmd(8'h10, 9'd4);
    check("t1_enb_first",  W'(bram_enb), W'(1));
    check("t1_addr_first", W'(bram_addrb), W'(8'h10));
    check("t1_no_valid",   W'(m_valid), W'(0));
    check("t1_busy",       W'(busy), W'(1));
    check("t1_cmd_ready",  W'(cmd_ready), W'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t1_valid", W'(m_valid), W'(1));
      check("t1_data",  m_data, W'(8'h10 + k));
      check("t1_last",  W'(m_last), W'(k == 3));
    end
    tick();
    check("t1_done",       W'(done), W'(1));
    check("t1_done_empty", W'(m_valid), W'(0));
    tick();
    check("t1_done_pulse", W'(done), W'(0));
    check("t1_idle_ready", W'(cmd_ready), W'(1));
    check("t1_idle_busy",  W'(busy), W'(0));

    // Address wrap from 0xFE; a command offered mid-burst must be ignored.
    wrap_addr[0] = 8'hFE;
    wrap_addr[1] = 8'hFF;
    wrap_addr[2] = 8'h00;
    wrap_addr[3] = 8'h01;
    send_cmd(8'hFE, 9'd4);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        check("t2_enb",  W'(bram_enb), W'(1));
        check("t2_addr", W'(bram_addrb), W'(wrap_addr[k]));
      end
      if (k >= 1) begin
        check("t2_data", m_data, W'(wrap_addr[k-1]));
        check("t2_last", W'(m_last), W'(k == 4));
      end
      if (k == 2) begin
        cmd_valid     = 1'b1;
        cmd_base_addr = 8'h80;
        cmd_len       = 9'd5;
      end
      if (k == 3) begin
        cmd_valid = 1'b0;
        cmd_len   = '0;
      end
      tick();
    end
    check("t2_done", W'(done), W'(1));
    tick();
    check("t2_idle", W'(cmd_ready), W'(1));

    // Backpressure: 16 words with consumer stalled for 10 cycles.
    m_ready = 1'b0;
    send_cmd(8'h00, 9'd16);
    issues = 0;
    for (int c = 0; c < 10; c++) begin
      if (bram_enb) issues++;
      if (c < 9) tick();
    end
    check("t3_issues_stalled", W'(issues), W'(4));
    check("t3_head_valid",     W'(m_valid), W'(1));
    check("t3_head_data",      m_data, W'(0));
    m_ready   = 1'b1;
    got       = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 64 && !seen_done; c++) begin
      if (m_valid) begin
        check("t3_data", m_data, W'(got));
        check("t3_last", W'(m_last), W'(got == 15));
        got++;
      end
      tick();
      if (done) seen_done = 1'b1;
    end
    check("t3_word_count",  W'(got), W'(16));
    check("t3_done_seen",   W'(seen_done), W'(1));
    check("t3_done_empty",  W'(m_valid), W'(0));
    tick();
    check("t3_idle", W'(cmd_ready), W'(1));

    // Zero-length command goes straight to DONE.
    send_cmd(8'h33, 9'd0);
    check("t4_done",   W'(done), W'(1));
    check("t4_enb",    W'(bram_enb), W'(0));
    check("t4_valid",  W'(m_valid), W'(0));
    check("t4_ready",  W'(cmd_ready), W'(0));
    tick();
    check("t4_done_pulse", W'(done), W'(0));
    check("t4_enb_after",  W'(bram_enb), W'(0));
    check("t4_valid_after", W'(m_valid), W'(0));
    check("t4_idle",       W'(cmd_ready), W'(1));

    // Reset asserted between edges after three of eight words were taken.
    send_cmd(8'h20, 9'd8);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_data", m_data, W'(8'h20 + k));
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("t5_ready_release", W'(cmd_ready), W'(1));
    check("t5_empty_release", W'(m_valid), W'(0));
    tick();
    check("t5_still_empty", W'(m_valid), W'(0));
    send_cmd(8'h40, 9'd2);
    check("t5_no_stale", W'(m_valid), W'(0));
    tick();
    check("t5_w0_data", m_data, W'(8'h40));
    check("t5_w0_last", W'(m_last), W'(0));
    tick();
    check("t5_w1_data", m_data, W'(8'h41));
    check("t5_w1_last", W'(m_last), W'(1));
    tick();
    check("t5_done",  W'(done), W'(1));
    check("t5_empty", W'(m_valid), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
